out_reg_turn_cell: RTL
======================

// Module: out_reg_turn_cell
// PURPOSE
//   Output-direction I/O cell simulation model: drives one pad from fabric.
//   It is the transmit counterpart of the input register/buffer cell, and
//   shares the same IQC clock and QRT reset naming.
//   It registers the output data and runs an output-enable turnaround FSM.
//   The FSM keeps the pad released for TURNAROUND cycles before driving,
//   which avoids bus contention on bidirectional pads.
//   It sits between fabric logic and the VPR output pad in the I/O tile.
//
// PARAMETERS
//   MODE        "OUT_REG"  "OUT_REG" registered path + FSM; "OUT_BUFF" combinational bypass
//   TURNAROUND  2          released cycles before drive, legal 0..15
//   INIT        1'b0       reset value of the output data register
//
// PORTS
//   IQC    in   1  cell clock, rising edge
//   QRT    in   1  asynchronous active-low reset
//   OQI    in   1  output data from fabric
//   OQE    in   1  data register clock enable
//   IQE    in   1  output-enable request (1 = want to drive pad)
//   OQZ    out  1  data toward pad (registered in OUT_REG)
//   OEN    out  1  pad driver enable, active high
//   TBUSY  out  1  1 while in turnaround (state TURN)
//   PAD    out  1  resolved pad: OEN ? OQZ : 1'bz
//
// BEHAVIOUR
//   Reset (QRT=0, async, takes effect immediately):
//   - dq=INIT, state=HIZ, cnt=0, OEN=0, TBUSY=0, PAD=z.
//   - Leaving reset is synchronous: first state update on the first IQC edge with QRT=1.
//   Data path (OUT_REG):
//   - dq <= OQI on an edge with OQE=1, otherwise held.
//   - OQZ=dq, so data latency is 1 edge.
//   - dq updates regardless of FSM state.
//   FSM states HIZ/TURN/DRIVE; OEN and TBUSY are registered decodes:
//   - OEN = state==DRIVE; TBUSY = state==TURN.
//   - HIZ: IQE=1 -> TURN with cnt=TURNAROUND-1; if TURNAROUND==0, go directly to DRIVE.
//   - TURN:
//     - IQE=0 -> HIZ, cnt cleared (abort, no drive).
//     - else if cnt==0 -> DRIVE.
//     - else cnt <= cnt-1.
//   - DRIVE: IQE=0 -> HIZ (release after 1 edge, no turnaround on release); else stay.
//   Latency:
//   - IQE rise sampled at edge k gives OEN=1 after edge k+TURNAROUND.
//   - IQE fall sampled at edge k gives OEN=0 after edge k.
//   Boundary cases:
//   - IQE toggling 1->0->1 during TURN restarts the full turnaround.
//   - IQE held 1 through reset release starts TURN at the first edge.
//   - cnt is 4 bits; TURNAROUND>15 is a parameter error ($fatal at elaboration).
//   OUT_BUFF mode:
//   - OQZ=OQI, OEN=IQE, combinational; TBUSY=0.
//   - Registers are held in reset and QRT/IQC are ignored for outputs.
//   PAD is driven only when OEN=1; the X/Z check on PAD happens in the pad model.
//
// TESTING
//   1 Reset: QRT=0 mid-DRIVE -> OEN=0, PAD=z, OQZ=INIT at once, without a clock edge.
//   2 Turnaround=2: IQE 0->1 at edge 0, held -> TBUSY=1 after edges 0,1; OEN=1 after edge 2.
//   3 Abort: IQE=1 at edge 0, 0 at edge 1 -> TBUSY drops after edge 1, OEN never asserts.
//   4 Release: in DRIVE, IQE=0 at edge k -> OEN=0, PAD=z after edge k.
//   5 Data: OQE=1, OQI=1,0,1 -> OQZ=1,0,1 one edge later; OQE=0 holds the value.
//   6 TURNAROUND=0 and MODE="OUT_BUFF": OEN follows IQE after 1 edge / combinationally; TBUSY stays 0.

Source files
------------

// File: rtl/out_reg_turn_cell.sv
// Output-direction I/O cell: registered pad data plus an output-enable
// turnaround FSM that keeps the pad released before it drives, or a combinational bypass.
module out_reg_turn_cell #(
  parameter              MODE       = "OUT_REG",
  parameter int unsigned TURNAROUND = 2,
  parameter logic        INIT       = 1'b0
) (
  input  logic IQC,
  input  logic QRT,
  input  logic OQI,
  input  logic OQE,
  input  logic IQE,
  output logic OQZ,
  output logic OEN,
  output logic TBUSY,
  output logic PAD
);

  localparam bit IS_BUFF = (MODE == "OUT_BUFF");
  localparam logic [3:0] TURN_LOAD = (TURNAROUND == 0) ? 4'd0 : 4'(TURNAROUND - 1);

  if (TURNAROUND > 15) begin : g_bad_turn
    $fatal(1, "out_reg_turn_cell: TURNAROUND must be 0..15");
  end
  if (MODE != "OUT_REG" && MODE != "OUT_BUFF") begin : g_bad_mode
    $fatal(1, "out_reg_turn_cell: MODE must be OUT_REG or OUT_BUFF");
  end

  typedef enum logic [1:0] {
    HIZ   = 2'd0,
    TURN  = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       dq;
  logic       oen_q, tbusy_q;
  logic       rst_n;

  // Bypass mode pins every register in reset so only the combinational path is live.
  assign rst_n = IS_BUFF ? 1'b0 : QRT;

  always_ff @(posedge IQC or negedge rst_n) begin
    if (!rst_n) begin
      dq <= INIT;
    end else if (OQE) begin
      dq <= OQI;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      HIZ: begin
        if (IQE) begin
          if (TURNAROUND == 0) begin
            state_n = DRIVE;
          end else begin
            state_n = TURN;
            cnt_n   = TURN_LOAD;
          end
        end
      end
      TURN: begin
        if (!IQE) begin
          state_n = HIZ;
          cnt_n   = '0;
        end else if (cnt == '0) begin
          state_n = DRIVE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      DRIVE: begin
        if (!IQE) begin
          state_n = HIZ;
        end
      end
      default: begin
        state_n = HIZ;
        cnt_n   = '0;
      end
    endcase
  end

  // OEN/TBUSY are registered decodes of the next state so they glitch-free track the state.
  always_ff @(posedge IQC or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HIZ;
      cnt     <= '0;
      oen_q   <= 1'b0;
      tbusy_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      oen_q   <= (state_n == DRIVE);
      tbusy_q <= (state_n == TURN);
    end
  end

  assign OQZ   = IS_BUFF ? OQI  : dq;
  assign OEN   = IS_BUFF ? IQE  : oen_q;
  assign TBUSY = IS_BUFF ? 1'b0 : tbusy_q;
  assign PAD   = OEN ? OQZ : 1'bz;

endmodule
